// File: rtl/mssd_demux.sv
// mssd_demux: framed serial stream demultiplexer routing payload bits to one of four ports.
// Define MSSD_STICKY_ERR_EN to hold error high from the first zero-length frame until rst.
module mssd_demux #(
  parameter int BYTE_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serIn,
  output logic       p0,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic [1:0] d,
  output logic       error,
  output logic       outValid
);
  localparam int BW = BYTE_BITS > 1 ? $clog2(BYTE_BITS) : 1;
  typedef enum logic [2:0] {IDLE, DEST, LEN, DATA, ERR} state_t;
  state_t        r_state;
  logic [BW-1:0] r_bit;
  logic [3:0]    r_byte;
  logic [3:0]    r_len;
  logic [1:0]    r_hdr;
  logic [1:0]    r_d;
  logic          r_error;
  logic [3:0]    w_len_nxt;
  logic          w_bit_last;
  logic          w_dv;
  assign w_len_nxt  = {r_len[2:0], serIn};
  assign w_bit_last = r_bit == BW'(BYTE_BITS - 1);
  assign w_dv       = r_state == DATA;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_byte  <= '0;
      r_len   <= '0;
      r_hdr   <= '0;
      r_d     <= '0;
      r_error <= 1'b0;
    end else begin
`ifndef MSSD_STICKY_ERR_EN
      r_error <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          r_hdr <= '0;
          if (!serIn) r_state <= DEST;
        end
        DEST: begin
          r_d   <= {r_d[0], serIn};
          r_hdr <= r_hdr + 2'd1;
          if (r_hdr == 2'd1) begin
            r_hdr   <= '0;
            r_state <= LEN;
          end
        end
        LEN: begin
          r_len <= w_len_nxt;
          r_hdr <= r_hdr + 2'd1;
          if (r_hdr == 2'd3) begin
            r_bit   <= '0;
            r_byte  <= '0;
            r_state <= w_len_nxt == 4'd0 ? ERR : DATA;
            if (w_len_nxt == 4'd0) r_error <= 1'b1;
          end
        end
        DATA: begin
          r_bit <= r_bit + 1'b1;
          if (w_bit_last) begin
            r_bit  <= '0;
            r_byte <= r_byte + 4'd1;
            if (r_byte == r_len - 4'd1) r_state <= IDLE;
          end
        end
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // payload is forwarded combinationally so the selected port has zero latency
  assign p0       = w_dv && r_d == 2'd0 && serIn;
  assign p1       = w_dv && r_d == 2'd1 && serIn;
  assign p2       = w_dv && r_d == 2'd2 && serIn;
  assign p3       = w_dv && r_d == 2'd3 && serIn;
  assign d        = r_d;
  assign error    = r_error;
  assign outValid = w_dv;
endmodule

// File: tb/tb_mssd_demux.sv
// tb_mssd_demux: directed self-checking bench for mssd_demux.
module tb_mssd_demux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serIn = 1'b1;
  logic       p0, p1, p2, p3;
  logic [1:0] d;
  logic       error, outValid;
  int total = 0;
  int bad = 0;
  logic [127:0] cap [4];
  int   ov_cnt, err_cnt, gap, last_gap;
  logic seen_ov, in_gap, stray;

  mssd_demux dut (
    .clk(clk), .rst(rst), .serIn(serIn),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .d(d), .error(error), .outValid(outValid)
  );

  always #5 clk = ~clk;

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) cap[k] = '0;
    ov_cnt = 0; err_cnt = 0; gap = 0; last_gap = -1;
    seen_ov = 1'b0; in_gap = 1'b0; stray = 1'b0;
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    serIn = b;
    #1;
    if (outValid) begin
      ov_cnt++;
      cap[0] = {cap[0][126:0], p0};
      cap[1] = {cap[1][126:0], p1};
      cap[2] = {cap[2][126:0], p2};
      cap[3] = {cap[3][126:0], p3};
      if (seen_ov && in_gap) last_gap = gap;
      in_gap  = 1'b0;
      seen_ov = 1'b1;
    end else begin
      if (seen_ov) begin
        if (!in_gap) begin
          in_gap = 1'b1;
          gap = 0;
        end
        gap++;
      end
      if (p0 | p1 | p2 | p3) stray = 1'b1;
    end
    if (error) err_cnt++;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b1);
  endtask

  task automatic send_frame(input logic [1:0] dst, input logic [3:0] n, input logic [119:0] data);
    drive(1'b0);
    drive(dst[1]); drive(dst[0]);
    for (int i = 3; i >= 0; i--) drive(n[i]);
    for (int i = 0; i < int'(n) * 8; i++) drive(data[int'(n) * 8 - 1 - i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serIn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({outValid, error, d, p3, p2, p1, p0} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000000", {outValid, error, d, p3, p2, p1, p0});
    end
    serIn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_route_d3();
    clear_obs();
    idle(2);
    send_frame(2'd3, 4'd2, 120'hABC9);
    idle(2);
    total++;
    if (ov_cnt !== 16) begin bad++; $display("FAIL d3_ov_cycles got=%0d want=16", ov_cnt); end
    total++;
    if (cap[3] !== 128'hABC9) begin bad++; $display("FAIL d3_p3_data got=%0h want=abc9", cap[3]); end
    total++;
    if ((cap[0] | cap[1] | cap[2]) !== 128'h0) begin bad++; $display("FAIL d3_other_ports got=%0h want=0", cap[0] | cap[1] | cap[2]); end
    total++;
    if (d !== 2'd3) begin bad++; $display("FAIL d3_dest got=%0d want=3", d); end
    total++;
    if (err_cnt !== 0) begin bad++; $display("FAIL d3_error got=%0d want=0", err_cnt); end
    total++;
    if (stray !== 1'b0) begin bad++; $display("FAIL d3_idle_ports got=%b want=0", stray); end
  endtask

  task automatic test_route_d2();
    idle(20);
    clear_obs();
    send_frame(2'd2, 4'd2, 120'hABCE);
    idle(2);
    total++;
    if (ov_cnt !== 16) begin bad++; $display("FAIL d2_ov_cycles got=%0d want=16", ov_cnt); end
    total++;
    if (cap[2] !== 128'hABCE) begin bad++; $display("FAIL d2_p2_data got=%0h want=abce", cap[2]); end
    total++;
    if ((cap[0] | cap[1] | cap[3]) !== 128'h0) begin bad++; $display("FAIL d2_other_ports got=%0h want=0", cap[0] | cap[1] | cap[3]); end
    total++;
    if (d !== 2'd2) begin bad++; $display("FAIL d2_dest got=%0d want=2", d); end
  endtask

  task automatic test_len_zero();
    int want_err;
    logic first_err;
    clear_obs();
    send_frame(2'd1, 4'd0, 120'h0);
    drive(1'b1);
    first_err = error;
    idle(2);
`ifdef MSSD_STICKY_ERR_EN
    want_err = 3;
`else
    want_err = 1;
`endif
    total++;
    if (first_err !== 1'b1) begin bad++; $display("FAIL len0_error_timing got=%b want=1", first_err); end
    total++;
    if (err_cnt !== want_err) begin bad++; $display("FAIL len0_error_cycles got=%0d want=%0d", err_cnt, want_err); end
    total++;
    if (ov_cnt !== 0) begin bad++; $display("FAIL len0_outvalid got=%0d want=0", ov_cnt); end
    clear_obs();
    send_frame(2'd1, 4'd1, 120'h3C);
    idle(2);
    total++;
    if (cap[1] !== 128'h3C || ov_cnt !== 8) begin bad++; $display("FAIL len0_next_frame got=%0h/%0d want=3c/8", cap[1], ov_cnt); end
`ifdef MSSD_STICKY_ERR_EN
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL len0_sticky got=%b want=1", error); end
`else
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL len0_error_clear got=%b want=0", error); end
`endif
  endtask

  task automatic test_reset_mid();
    clear_obs();
    drive(1'b0);
    drive(1'b0); drive(1'b0);
    drive(1'b0); drive(1'b0); drive(1'b1); drive(1'b1);
    drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b1); drive(1'b1);
    total++;
    if (ov_cnt !== 5 || cap[0] !== 128'h17) begin bad++; $display("FAIL rstmid_partial got=%0d/%0h want=5/17", ov_cnt, cap[0]); end
    @(negedge clk);
    rst = 1'b1;
    serIn = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({outValid, error, d, p3, p2, p1, p0} !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b want=00000000", {outValid, error, d, p3, p2, p1, p0});
    end
    rst = 1'b0;
    clear_obs();
    send_frame(2'd1, 4'd1, 120'h5A);
    idle(2);
    total++;
    if (cap[1] !== 128'h5A || ov_cnt !== 8) begin bad++; $display("FAIL rstmid_next_frame got=%0h/%0d want=5a/8", cap[1], ov_cnt); end
    total++;
    if (d !== 2'd1 || cap[0] !== 128'h0) begin bad++; $display("FAIL rstmid_route got=%0d/%0h want=1/0", d, cap[0]); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(2'd0, 4'd1, 120'hFF);
    send_frame(2'd3, 4'd1, 120'h00);
    idle(2);
    total++;
    if (ov_cnt !== 16) begin bad++; $display("FAIL b2b_ov_cycles got=%0d want=16", ov_cnt); end
    total++;
    if (last_gap !== 7) begin bad++; $display("FAIL b2b_gap got=%0d want=7", last_gap); end
    total++;
    if (cap[0] !== 128'hFF00) begin bad++; $display("FAIL b2b_p0_data got=%0h want=ff00", cap[0]); end
    total++;
    if (d !== 2'd3) begin bad++; $display("FAIL b2b_dest got=%0d want=3", d); end
  endtask

  task automatic test_max_len();
    clear_obs();
    send_frame(2'd0, 4'd15, {30{4'h5}});
    idle(2);
    total++;
    if (ov_cnt !== 120) begin bad++; $display("FAIL max_ov_cycles got=%0d want=120", ov_cnt); end
    total++;
    if (cap[0] !== {8'h00, {30{4'h5}}}) begin bad++; $display("FAIL max_p0_data got=%0h want=%0h", cap[0], {8'h00, {30{4'h5}}}); end
    total++;
    if ((cap[1] | cap[2] | cap[3]) !== 128'h0) begin bad++; $display("FAIL max_other_ports got=%0h want=0", cap[1] | cap[2] | cap[3]); end
    total++;
    if (outValid !== 1'b0) begin bad++; $display("FAIL max_return_idle got=%b want=0", outValid); end
  endtask

  initial begin
    test_reset();
    test_route_d3();
    test_route_d2();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    test_max_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
